// File: rtl/cpu_ctrl_seq.sv
// Decode/control sequencer for the 2-stage CPU: turns each accepted fetch word into
// datapath load strobes and a mux select, and inserts a programmable stall after jumps.
module cpu_ctrl_seq #(
    parameter  int OPW          = 4,
    parameter  int IMM_W        = 4,
    parameter  int NUM_GPR      = 4,
    parameter  int STALL_CYCLES = 1,
    localparam int INSN_W       = OPW + IMM_W,
    localparam int GPR_SELW     = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                insn_valid,
    input  logic [INSN_W-1:0]   insn,
    output logic                insn_ready,
    input  logic                hold,
    input  logic                flush,
    output logic                load_A,
    output logic                load_B,
    output logic                load_OUT,
    output logic                load_GPR,
    output logic                gprload,
    output logic [GPR_SELW-1:0] gpr_sel,
    output logic [NUM_GPR-1:0]  gpr_we,
    output logic [1:0]          mux_sel,
    output logic                stalling
);

    typedef enum logic {DECODE, STALL} state_t;

    localparam bit         STALL_EN   = (STALL_CYCLES > 0);
    localparam logic [7:0] STALL_INIT = STALL_EN ? 8'(STALL_CYCLES - 1) : 8'd0;

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic [3:0]          w_op;
    logic [GPR_SELW-1:0] w_idx;
    logic                w_accept;
    logic                w_jump;
    logic                w_unused;

    assign w_op     = insn[INSN_W-1 -: 4];
    assign w_idx    = insn[GPR_SELW-1:0];
    assign w_unused = ^insn;

    assign insn_ready = (r_state == DECODE) & ~hold & ~flush;
    // Reset gates acceptance so every strobe reads 0 while reset is asserted.
    assign w_accept   = insn_valid & insn_ready & reset;
    assign w_jump     = w_accept & (w_op[3:1] == 3'b111);
    assign stalling   = (r_state == STALL);

    always_comb begin
        load_A   = 1'b0;
        load_B   = 1'b0;
        load_OUT = 1'b0;
        load_GPR = 1'b0;
        gprload  = 1'b0;
        gpr_sel  = '0;
        gpr_we   = '0;
        mux_sel  = 2'b00;
        if (w_accept) begin
            casez (w_op)
                4'b00??: begin
                    load_A  = 1'b1;
                    mux_sel = w_op[1:0];
                end
                4'b01??: begin
                    load_B  = 1'b1;
                    mux_sel = {w_op[0], w_op[1]};
                end
                4'b100?: begin
                    load_OUT = 1'b1;
                    mux_sel  = {w_op[0], 1'b0};
                end
                4'b1010: begin
                    load_B  = 1'b1;
                    gprload = 1'b1;
                    gpr_sel = w_idx;
                end
                4'b1011: begin
                    load_GPR = 1'b1;
                    gpr_sel  = w_idx;
                    mux_sel  = 2'b10;
                    for (int i = 0; i < NUM_GPR; i++) begin
                        gpr_we[i] = (w_idx == GPR_SELW'(i));
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter is loaded one below the stall length so the zero cycle is the last stalled one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= DECODE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                DECODE: begin
                    if (w_jump && STALL_EN) begin
                        r_state <= STALL;
                        r_cnt   <= STALL_INIT;
                    end
                end
                STALL: begin
                    if (flush) begin
                        r_state <= DECODE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= DECODE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= DECODE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: two instances (3-cycle and zero-cycle jump stall)
// share stimulus; a reference model predicts each cycle and a monitor compares.
module tb_cpu_ctrl_seq;

    typedef struct packed {
        logic       ready;
        logic       la;
        logic       lb;
        logic       lo;
        logic       lg;
        logic       gl;
        logic [1:0] sel;
        logic [3:0] we;
        logic [1:0] mux;
        logic       stall;
    } exp_t;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic       insn_valid = 1'b0;
    logic [7:0] insn       = 8'h00;
    logic       hold       = 1'b0;
    logic       flush      = 1'b0;

    logic       rdy3, la3, lb3, lo3, lg3, gl3, st3;
    logic [1:0] sel3, mux3;
    logic [3:0] we3;
    logic       rdy0, la0, lb0, lo0, lg0, gl0, st0;
    logic [1:0] sel0, mux0;
    logic [3:0] we0;

    exp_t q3[$];
    exp_t q0[$];
    int   left3 = 0;
    int   left0 = 0;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    cpu_ctrl_seq #(.OPW(4), .IMM_W(4), .NUM_GPR(4), .STALL_CYCLES(3)) dut (
        .clock(clock), .reset(reset), .insn_valid(insn_valid), .insn(insn),
        .insn_ready(rdy3), .hold(hold), .flush(flush),
        .load_A(la3), .load_B(lb3), .load_OUT(lo3), .load_GPR(lg3), .gprload(gl3),
        .gpr_sel(sel3), .gpr_we(we3), .mux_sel(mux3), .stalling(st3)
    );

    cpu_ctrl_seq #(.OPW(4), .IMM_W(4), .NUM_GPR(4), .STALL_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .insn_valid(insn_valid), .insn(insn),
        .insn_ready(rdy0), .hold(hold), .flush(flush),
        .load_A(la0), .load_B(lb0), .load_OUT(lo0), .load_GPR(lg0), .gprload(gl0),
        .gpr_sel(sel0), .gpr_we(we0), .mux_sel(mux0), .stalling(st0)
    );

    always #5 clock = ~clock;

    // Reference: "left" is how many more cycles the controller refuses instructions.
    function automatic exp_t predict(input logic v, input logic [7:0] in,
                                     input logic h, input logic f, input logic r,
                                     input int left);
        exp_t e;
        int   op;
        e       = '0;
        op      = int'(in[7:4]);
        e.stall = r && (left > 0);
        e.ready = (left == 0) && !h && !f;
        if (v && e.ready && r) begin
            if (op < 4) begin
                e.la  = 1'b1;
                e.mux = 2'(op);
            end else if (op < 8) begin
                e.lb  = 1'b1;
                e.mux = 2'((op % 2) * 2 + (op / 2) % 2);
            end else if (op < 10) begin
                e.lo  = 1'b1;
                e.mux = 2'((op % 2) * 2);
            end else if (op == 10) begin
                e.lb  = 1'b1;
                e.gl  = 1'b1;
                e.sel = in[1:0];
            end else if (op == 11) begin
                e.lg  = 1'b1;
                e.sel = in[1:0];
                e.mux = 2'b10;
                e.we  = 4'(1 << in[1:0]);
            end
        end
        return e;
    endfunction

    function automatic int nextLeft(input logic v, input logic [7:0] in,
                                    input logic h, input logic f, input logic r,
                                    input int left, input int stallCycles);
        if (!r) return 0;
        if (left > 0) return f ? 0 : left - 1;
        if (v && !h && !f && in[7:5] == 3'b111) return stallCycles;
        return 0;
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] in,
                                 input logic h, input logic f, input logic r);
        @(negedge clock);
        insn_valid = v;
        insn       = in;
        hold       = h;
        flush      = f;
        reset      = r;
        #1;
        if (!r) begin
            left3 = 0;
            left0 = 0;
        end
        q3.push_back(predict(v, in, h, f, r, left3));
        q0.push_back(predict(v, in, h, f, r, left0));
        left3 = nextLeft(v, in, h, f, r, left3, 3);
        left0 = nextLeft(v, in, h, f, r, left0, 0);
    endtask

    task automatic checkOutput(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d insn=%h: got %b want %b (ready,lA,lB,lOUT,lGPR,gprload,sel,we,mux,stalling)",
                     name, cycle, insn, act, exp);
        end
    endtask

    // Monitor samples just before each rising edge, well after inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #4;
            cycle++;
            if (q3.size() > 0) begin
                e = q3.pop_front();
                checkOutput("stall3", {rdy3, la3, lb3, lo3, lg3, gl3, sel3, we3, mux3, st3}, e);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checkOutput("stall0", {rdy0, la0, lb0, lo0, lg0, gl0, sel0, we0, mux0, st0}, e);
            end
        end
    end

    initial begin
        applyStimulus(1, 8'h35, 0, 0, 0);
        applyStimulus(1, 8'h35, 1, 0, 0);
        applyStimulus(1, 8'h35, 0, 0, 1);
        applyStimulus(1, 8'h60, 0, 0, 1);
        applyStimulus(1, 8'h90, 0, 0, 1);
        applyStimulus(1, 8'hB2, 0, 0, 1);
        applyStimulus(1, 8'hA3, 0, 0, 1);
        applyStimulus(0, 8'h35, 0, 0, 1);

        applyStimulus(1, 8'hE0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h35, 0, 0, 1);

        applyStimulus(1, 8'hE0, 0, 0, 1);
        applyStimulus(1, 8'h35, 0, 0, 1);
        applyStimulus(1, 8'h35, 0, 1, 1);
        applyStimulus(1, 8'h35, 0, 0, 1);

        applyStimulus(1, 8'hE0, 0, 0, 1);
        applyStimulus(1, 8'h35, 1, 0, 1);
        applyStimulus(1, 8'h35, 0, 0, 0);
        applyStimulus(1, 8'h35, 0, 0, 1);

        applyStimulus(1, 8'h35, 1, 0, 1);
        applyStimulus(1, 8'h35, 0, 1, 1);
        applyStimulus(1, 8'hE0, 0, 0, 1);
        applyStimulus(1, 8'h35, 0, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 63) != 0);
        end
        applyStimulus(0, 8'h00, 0, 0, 1);

        @(negedge clock);
        #6;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
